interp_chain: RTL
=================

INTERP_CHAIN -- requirements
Module: interp_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning sample width in bits (unsigned samples).
REQ-002 SHALL have parameter RATIO, default 10, meaning the upsampling factor of each stage (range 2..16).
REQ-003 SHALL have parameter STAGES, default 3, meaning the number of cascaded stages (range 1..4); total ratio N = RATIO^STAGES.
REQ-004 SHALL have port clk  in  1  system clock; the block uses one clock only.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port run  in  1  when high, the rate counters advance; when low, all state freezes.
REQ-007 SHALL have port mode  in  2  interpolation mode: 0 linear, 1 hold, 2 bypass, 3 reserved (treated as linear).
REQ-008 SHALL have port sample_in  in  WIDTH  base-rate input sample, captured on the cycle in_req is high.
REQ-009 SHALL have port in_req  out  1  one-cycle strobe requesting and capturing the next base-rate sample.
REQ-010 SHALL have port sample_out  out  WIDTH  clock-rate output sample (feeds the PDM).
REQ-011 SHALL have port mode_act  out  2  mode currently in effect.

Function
REQ-012 Rate strobes: st[STAGES] = run; digit counters d[s] (0..RATIO-1, s = 0..STAGES-1) SHALL increment on st[s+1] and wrap to 0 after RATIO-1; st[s] = st[s+1] AND (d[s] == RATIO-1).
REQ-013 in_req SHALL equal st[0]: one pulse every N run-cycles, the first on the N-th run-high cycle after reset release.
REQ-014 Stage s (input in_0 = sample_in, in_s = y[s-1]) SHALL do the following on st[s]: x0 <= x1, x1 <= in_s, k <= 0.
REQ-015 On each st[s+1] cycle without st[s], stage s SHALL set k <= k+1, saturating at RATIO-1.
REQ-016 On every st[s+1] cycle, stage s SHALL register y[s] <= f(x0, x1, k) using its pre-update register values.
REQ-017 Linear mode: f = (x0*(RATIO-k) + x1*k) / RATIO, truncating unsigned division, with an intermediate width of WIDTH + clog2(RATIO) + 1 bits; the result is always within [min(x0,x1), max(x0,x1)].
REQ-018 Hold mode: f = x0.
REQ-019 Bypass mode: every stage SHALL output x1, so sample_out holds the last sample_in captured, delayed through the stages.
REQ-020 sample_out SHALL equal y[STAGES-1].
REQ-021 mode SHALL be sampled into mode_act only on st[0] cycles; a change mid-period takes effect at the next in_req.
REQ-022 run low: no counter, stage register or output SHALL change, and in_req SHALL stay 0; on resuming, counting SHALL continue from the frozen digit values.
REQ-023 Simultaneous st[s] and st[s+1]: the load of REQ-014 SHALL take priority over the k increment of REQ-015, and the y update of REQ-016 SHALL still occur.
REQ-024 With run held high and sample_in constant at C for at least 3 base periods (3N cycles), sample_out SHALL equal C in all modes.

Reset
REQ-025 While reset is high, the following SHALL be 0: all digits, x0, x1, k, y, in_req, sample_out; mode_act SHALL be 0 (linear).
REQ-026 Reset SHALL take priority over run and over all strobes; asserting reset mid-period SHALL discard any partial interpolation.

Structure
REQ-027 Package interp_pkg SHALL hold the mode encoding constants, a compile-time power function for N, and the clog2 helper.
REQ-028 The per-stage datapath SHALL be sub-module interp_stage (parameters WIDTH and RATIO), instantiated STAGES times via generate.
REQ-029 The strobe generator SHALL live in interp_chain; the stages SHALL share no state except the strobes and mode_act.

Verification
REQ-030 Scenario: STAGES=1, RATIO=10, linear, sample_in 0 then 100 -> within one base period the sample_out sequence is 0,10,20,...,90.
REQ-031 Scenario: same configuration, hold mode, inputs 40 then 200 -> 40 held for 10 cycles, then 200.
REQ-032 Scenario: default parameters, run=1 -> in_req period is exactly 1000 cycles; after reset, the first in_req occurs on cycle 1000.
REQ-033 Scenario: default parameters, constant 255 for 3000 cycles -> sample_out=255; a step to 0 decreases sample_out monotonically with no value above 255.
REQ-034 Scenario: toggle run low for 37 cycles mid-period -> in_req is delayed by exactly 37 cycles and sample_out is frozen during the gap.
REQ-035 Scenario: change mode mid-period, and assert reset mid-period -> mode_act changes only at the next in_req; reset returns all outputs to 0 on the following cycle.

Source files
------------

// File: rtl/interp_pkg.sv
// -----------------------------------------------------------------------------
// interp_pkg
// Shared definitions for the cascaded interpolator:
//   - mode_e      : interpolation mode encoding carried on mode / mode_act
//   - clog2()     : ceiling log2, used to size digit and phase counters
//   - ipow()      : integer power, gives the total ratio N = RATIO**STAGES
// -----------------------------------------------------------------------------
package interp_pkg;

  typedef enum logic [1:0] {
    MODE_LINEAR = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_BYPASS = 2'd2,
    MODE_RSVD   = 2'd3   // behaves as linear
  } mode_e;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 32'sd1;
    end
    return result;
  endfunction

  // base**exp for small non-negative exponents.
  function automatic int ipow(input int base, input int exp);
    int result;
    result = 32'sd1;
    for (int i = 32'sd0; i < exp; i++) begin
      result = result * base;
    end
    return result;
  endfunction

endpackage

// File: rtl/interp_stage.sv
// -----------------------------------------------------------------------------
// interp_stage
// One upsampling stage. On ld it shifts a new input sample into its two-tap
// history (x0 <= x1, x1 <= in) and restarts the phase counter k. On every adv
// it emits y = f(x0, x1, k) from the values held before this edge, and, when
// not loading, advances k (saturating at RATIO-1).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   ld          : slow strobe of this stage (new input sample)
//   adv         : fast strobe of this stage (new output sample)
//   mode        : mode in effect (linear / hold / bypass / reserved=linear)
//   in_sample   : input sample from the previous stage (or the chain input)
//   y_out       : registered output sample
// -----------------------------------------------------------------------------
module interp_stage
  import interp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             adv,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_sample,
  output logic [WIDTH-1:0] y_out
);

  localparam int KW = clog2(RATIO);
  // One extra bit so that the weight RATIO-k (up to RATIO) always fits.
  localparam int IW = WIDTH + KW + 1;
  localparam logic [KW-1:0] K_MAX   = KW'(RATIO - 32'sd1);
  localparam logic [IW-1:0] RATIO_W = IW'(RATIO);

  logic [WIDTH-1:0] x0_q, x0_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]    k_q, k_d;
  logic [IW-1:0]    num_s;
  logic [WIDTH-1:0] lin_s;
  logic [WIDTH-1:0] f_s;

  // Weighted blend of the two history taps, truncated toward zero.
  always_comb begin
    num_s = IW'(x0_q) * (RATIO_W - IW'(k_q)) + IW'(x1_q) * IW'(k_q);
    lin_s = WIDTH'(num_s / RATIO_W);
  end

  // Select the output function for the mode in effect.
  always_comb begin
    f_s = lin_s;
    case (mode)
      MODE_HOLD:   f_s = x0_q;
      MODE_BYPASS: f_s = x1_q;
      MODE_LINEAR: f_s = lin_s;
      MODE_RSVD:   f_s = lin_s;
      default:     f_s = lin_s;
    endcase
  end

  // Next-state: load has priority over the phase increment; y updates on adv.
  always_comb begin
    x0_d = x0_q;
    x1_d = x1_q;
    k_d  = k_q;
    y_d  = y_q;
    if (ld) begin
      x0_d = x1_q;
      x1_d = in_sample;
      k_d  = '0;
    end else if (adv) begin
      if (k_q == K_MAX) begin
        k_d = k_q;
      end else begin
        k_d = k_q + KW'(1'b1);
      end
    end else begin
      k_d = k_q;
    end
    if (adv) begin
      y_d = f_s;
    end else begin
      y_d = y_q;
    end
  end

  // Stage state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q <= '0;
      x1_q <= '0;
      k_q  <= '0;
      y_q  <= '0;
    end else begin
      x0_q <= x0_d;
      x1_q <= x1_d;
      k_q  <= k_d;
      y_q  <= y_d;
    end
  end

  assign y_out = y_q;

endmodule

// File: rtl/interp_chain.sv
// -----------------------------------------------------------------------------
// interp_chain
// Cascade of STAGES interpolators, each upsampling by RATIO, for a total ratio
// of RATIO**STAGES. A mixed-radix counter (one digit per stage) produces the
// rate strobes: st[STAGES] is run, st[s] fires when st[s+1] fires and digit s
// is at its terminal count. Stage s loads on st[s] and outputs on st[s+1].
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset
//   run        : enables counting; when low every register holds
//   mode       : requested interpolation mode, adopted at each in_req
//   sample_in  : base-rate input, captured on the in_req cycle
//   in_req     : one-cycle strobe per base period (st[0])
//   sample_out : clock-rate output sample (last stage output)
//   mode_act   : mode currently in effect
// -----------------------------------------------------------------------------
module interp_chain
  import interp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int RATIO  = 10,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] sample_in,
  output logic             in_req,
  output logic [WIDTH-1:0] sample_out,
  output logic [1:0]       mode_act
);

  localparam int DW = clog2(RATIO);
  localparam logic [DW-1:0] D_MAX = DW'(RATIO - 32'sd1);

  logic [DW-1:0]    d_q [STAGES];
  logic [DW-1:0]    d_d [STAGES];
  logic [STAGES-1:0] at_max;
  logic [STAGES:0]  st;
  logic [1:0]       mode_act_q, mode_act_d;
  logic [WIDTH-1:0] y_s      [STAGES];
  logic [WIDTH-1:0] stage_in [STAGES];

  // Flag digits sitting at their terminal count.
  always_comb begin
    at_max = '0;
    for (int s = 32'sd0; s < STAGES; s++) begin
      at_max[s] = (d_q[s] == D_MAX);
    end
  end

  // Ripple strobes from the fastest digit (STAGES-1) down to the slowest.
  // Reset gates the top strobe so in_req stays low while reset is held.
  always_comb begin
    logic acc;
    st         = '0;
    acc        = run & ~reset;
    st[STAGES] = acc;
    for (int s = STAGES - 32'sd1; s >= 32'sd0; s--) begin
      acc   = acc & at_max[s];
      st[s] = acc;
    end
  end

  // Advance each digit on its incoming strobe, wrapping after RATIO-1.
  always_comb begin
    d_d = d_q;
    for (int s = 32'sd0; s < STAGES; s++) begin
      if (st[s+1]) begin
        if (at_max[s]) begin
          d_d[s] = '0;
        end else begin
          d_d[s] = d_q[s] + DW'(1'b1);
        end
      end else begin
        d_d[s] = d_q[s];
      end
    end
  end

  // Adopt the requested mode only at a base-period boundary.
  always_comb begin
    if (st[0]) begin
      mode_act_d = mode;
    end else begin
      mode_act_d = mode_act_q;
    end
  end

  // Counter and mode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 32'sd0; s < STAGES; s++) begin
        d_q[s] <= '0;
      end
      mode_act_q <= MODE_LINEAR;
    end else begin
      for (int s = 32'sd0; s < STAGES; s++) begin
        d_q[s] <= d_d[s];
      end
      mode_act_q <= mode_act_d;
    end
  end

  // Stage 0 takes the chain input; later stages take the previous stage output.
  always_comb begin
    for (int s = 32'sd0; s < STAGES; s++) begin
      if (s == 32'sd0) begin
        stage_in[s] = sample_in;
      end else begin
        stage_in[s] = y_s[s-1];
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    interp_stage #(
      .WIDTH (WIDTH),
      .RATIO (RATIO)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .ld        (st[g]),
      .adv       (st[g+1]),
      .mode      (mode_act_q),
      .in_sample (stage_in[g]),
      .y_out     (y_s[g])
    );
  end

  assign in_req     = st[0];
  assign sample_out = y_s[STAGES-1];
  assign mode_act   = mode_act_q;

endmodule
